// File: rtl/delay_line_deserializer_if.sv
// Serial-in / parallel-out bundle for the delay-line deserializer.
// The master drives bits and ready; the slave (receiver) returns words and status.
interface delay_line_deserializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in0;
  logic             in_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             frame_err;
  logic             overrun;
  logic             busy;

  modport master (
    output in0, in_valid, out_ready,
    input  out_data, out_valid, frame_err, overrun, busy
  );

  modport slave (
    input  in0, in_valid, out_ready,
    output out_data, out_valid, frame_err, overrun, busy
  );
endinterface

// File: rtl/delay_line_deserializer.sv
// Frames start/data/stop bits from the delay-line output into WIDTH-bit words,
// buffers them in a DEPTH-entry FIFO and reports framing errors and overruns.
module delay_line_deserializer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  delay_line_deserializer_if.slave  bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             frame_err_q;
  logic             overrun_q;

  logic push, pop, full, push_ok;

  always_comb begin
    push    = bus.in_valid && (state_q == STOP) && !bus.in0;
    pop     = (count_q != '0) && bus.out_ready;
    full    = (count_q == (AW+1)'(DEPTH));
    // A pop on the same edge frees the head slot, so a push into a full FIFO still lands.
    push_ok = push && (!full || pop);
    count_d = count_q;
    if (push_ok && !pop)
      count_d = count_q + 1'b1;
    else if (!push_ok && pop)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= push && !push_ok;
      if (bus.in_valid) begin
        unique case (state_q)
          IDLE: begin
            if (bus.in0) begin
              state_q <= DATA;
              cnt_q   <= '0;
            end
          end
          DATA: begin
            shift_q[cnt_q] <= bus.in0;
            cnt_q          <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1))
              state_q <= STOP;
          end
          STOP: begin
            frame_err_q <= bus.in0;
            state_q     <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
      if (push_ok) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.out_valid = (count_q != '0);
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: doc/delay_line_deserializer.md
Name: delay_line_deserializer

Overview:
- Receiving end of the team's serial delay-line path. The delay-line chain carries one bit per strobe; this block sits at the far end of it.
- Detects framed serial words on the delay-line output and assembles them LSB-first into WIDTH-bit parallel words.
- Buffers completed words in a small FIFO and presents them on a valid/ready interface.
- Flags framing errors and overruns as single-cycle pulses.

Parameters:
- WIDTH, 8: data bits per frame (2..32).
- DEPTH, 2: output FIFO entries. Power of two, 2..8.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in0  in  1  serial bit from the delay-line output.
- in_valid  in  1  bit strobe; in0 is sampled only on a rising edge where in_valid=1.
- out_data  out  WIDTH  word at the FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head word when out_valid & out_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled as 1.
- overrun  out  1  one-cycle pulse: good frame dropped because the FIFO was full.
- busy  out  1  receiver is not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; shift register, bit counter, FIFO pointers and count all zero.
  - out_valid=0, out_data=0, frame_err=0, overrun=0, busy=0.
- Frame format, one bit per accepted strobe: start bit 1, then WIDTH data bits LSB first, then stop bit 0.
- Strobes with in_valid=0 are ignored; any gap length between strobes is legal.
- State machine, advancing only on accepted strobes:
  - IDLE: in0=1 -> DATA with bit counter cleared. in0=0 -> stay in IDLE (idle line).
  - DATA: shift in0 into bit position [counter], increment counter. After WIDTH bits -> STOP.
  - STOP, in0=0: the assembled word is a good frame -> push. Go to IDLE.
  - STOP, in0=1: frame_err=1 for the next cycle, word discarded, go to IDLE. This stop bit is not treated as a new start bit.
- busy=1 in DATA and STOP.
- Latency:
  - The word is written on the same edge that samples a good stop bit.
  - out_valid=1 and out_data=word are visible immediately after that edge, when the FIFO was empty.
- FIFO:
  - Registered storage; out_data always shows the head entry and is combinational from the head pointer.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle are both performed and count is unchanged. This holds when the FIFO is full: a simultaneous pop frees the slot, so the push succeeds.
  - Push with count==DEPTH and no pop: word dropped, overrun=1 for one cycle, FIFO contents unchanged.
  - Pointers wrap modulo DEPTH.
  - out_ready while out_valid=0 has no effect.
- frame_err and overrun are registered pulses, high for exactly one cycle per event; they never stick.
- Reset asserted mid-frame or with a non-empty FIFO: the partial frame and all buffered words are lost, and all outputs return to their reset values immediately (asynchronously).
- out_data is held stable while out_valid=1 and out_ready=0.

Test Plan:
- Reset then one frame, WIDTH=8, strobe every cycle: bits 1, 1,0,1,0,0,1,0,1, 0. Expect out_valid=1 after the stop-bit edge and out_data=8'hA5; out_ready=1 then drops out_valid.
- Same frame with in_valid toggled 1/0 each cycle (gapped strobes): same 8'hA5; busy=1 from the start bit through the stop bit.
- Frame 8'h3C sent with stop bit 1: frame_err high exactly one cycle, out_valid stays 0, busy=0 afterwards. The next good frame 8'h01 is received correctly.
- out_ready=0, send 8'h11, 8'h22, 8'h33 (DEPTH=2): overrun pulses once on the third stop bit. Then raise out_ready: outputs are 8'h11 then 8'h22, then out_valid=0.
- FIFO full (8'h11, 8'h22) with out_ready=1 on the same edge as the third good stop bit (8'h33): no overrun; subsequent reads are 8'h22 then 8'h33.
- Assert rst_n=0 after 4 data bits of a frame with 1 word buffered: out_valid, busy and out_data go to 0 immediately. After release, idle 0 bits produce no output and a new frame 8'hFF is received.
